// File: rtl/codiq_chip_sequencer.sv
// -----------------------------------------------------------------------------
// codiq_chip_sequencer
//   Feeds the O-QPSK IQ coder (TL_codeur_IQ) from an upstream valid/ready chip
//   source. One chip is issued every DIV clocks: b_in takes the new chip and
//   en_2MHz pulses for one cycle, while mem_state frames the coder window.
//
// Parameters
//   DIV    clk cycles per chip slot (2..255)
//   LEN_W  width of frame_len / chip_count
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   start, abort           frame start request (IDLE only), synchronous abort
//   frame_len              chips per frame, captured on an accepted start
//   chip_valid, chip_data  upstream chip source
//   chip_ready             pop strobe to the upstream source
//   coder_ready, dac_ready downstream readiness, checked at issue slots
//   b_in, en_2MHz          chip and chip strobe to the coder
//   mem_state              coder frame window (WAIT_DAC..FLUSH)
//   busy, done             activity flag, 1-cycle frame-complete pulse
//   underrun               sticky: source empty at an issue slot
//   chip_count             chips issued in the current or last frame
// -----------------------------------------------------------------------------
module codiq_chip_sequencer #(
   parameter int DIV   = 25,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             chip_valid,
   input  logic             chip_data,
   output logic             chip_ready,
   input  logic             coder_ready,
   input  logic             dac_ready,
   output logic             b_in,
   output logic             en_2MHz,
   output logic             mem_state,
   output logic             busy,
   output logic             done,
   output logic             underrun,
   output logic [LEN_W-1:0] chip_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DAC,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   localparam logic [7:0] TICK_LAST = 8'(DIV - 1);
   localparam logic [7:0] TICK_ONE  = 8'd1;

   state_t           state_q, state_d;
   logic [7:0]       tick_q, tick_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             underrun_q, underrun_d;
   logic             b_in_q, b_in_d;
   logic             en_q, en_d;
   logic             pop_q, pop_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             mem_q, mem_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         len_q      <= '0;
         count_q    <= '0;
         underrun_q <= 1'b0;
         b_in_q     <= 1'b0;
         en_q       <= 1'b0;
         pop_q      <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         mem_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         len_q      <= len_d;
         count_q    <= count_d;
         underrun_q <= underrun_d;
         b_in_q     <= b_in_d;
         en_q       <= en_d;
         pop_q      <= pop_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         mem_q      <= mem_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      len_d      = len_q;
      count_d    = count_q;
      underrun_d = underrun_q;
      b_in_d     = b_in_q;
      en_d       = 1'b0;
      pop_d      = 1'b0;
      done_d     = 1'b0;

      if (abort) begin
         // abort wins over start and issue; count, underrun and b_in are held
         state_d = S_IDLE;
         tick_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start && (frame_len != '0)) begin
                  len_d      = frame_len;
                  count_d    = '0;
                  underrun_d = 1'b0;
                  state_d    = S_WAIT_DAC;
               end
            end
            S_WAIT_DAC: begin
               if (dac_ready) begin
                  state_d = S_RUN;
                  tick_d  = '0;
               end
            end
            S_RUN: begin
               if (tick_q == '0) begin
                  // readiness is checked only at a slot; not ready holds tick at 0
                  if (dac_ready && coder_ready) begin
                     if (chip_valid) begin
                        b_in_d = chip_data;
                        en_d   = 1'b1;
                        pop_d  = 1'b1;
                        if (count_q != '1) begin
                           count_d = count_q + LEN_W'(1);
                        end
                        if (count_q == (len_q - LEN_W'(1))) begin
                           state_d = S_FLUSH;
                           tick_d  = '0;
                        end else begin
                           tick_d = TICK_ONE;
                        end
                     end else begin
                        underrun_d = 1'b1;
                        state_d    = S_FLUSH;
                        tick_d     = '0;
                     end
                  end
               end else begin
                  tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 8'd1;
               end
            end
            S_FLUSH: begin
               if (tick_q == TICK_LAST) begin
                  state_d = S_DONE;
                  tick_d  = '0;
               end else begin
                  tick_d = tick_q + 8'd1;
               end
            end
            S_DONE: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               tick_d  = '0;
            end
         endcase
      end

      // status flags are registered from the next state so they track state_q
      busy_d = (state_d != S_IDLE);
      mem_d  = (state_d == S_WAIT_DAC) || (state_d == S_RUN) || (state_d == S_FLUSH);
   end

   assign chip_ready = pop_q;
   assign b_in       = b_in_q;
   assign en_2MHz    = en_q;
   assign mem_state  = mem_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign underrun   = underrun_q;
   assign chip_count = count_q;

endmodule

// File: tb/tb_codiq_chip_sequencer.sv
// -----------------------------------------------------------------------------
// tb_codiq_chip_sequencer
//   Self-checking bench for codiq_chip_sequencer (DIV=25, LEN_W=16). Chips
//   loaded into the source model are also pushed to a scoreboard queue and
//   popped/compared on every en_2MHz strobe. Each scenario task checks timing,
//   counts and flags inline.
// -----------------------------------------------------------------------------
module tb_codiq_chip_sequencer;

   localparam int DIV   = 25;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [LEN_W-1:0] frame_len = '0;
   logic             chip_valid = 1'b0;
   logic             chip_data = 1'b0;
   logic             chip_ready;
   logic             coder_ready = 1'b1;
   logic             dac_ready = 1'b1;
   logic             b_in;
   logic             en_2MHz;
   logic             mem_state;
   logic             busy;
   logic             done;
   logic             underrun;
   logic [LEN_W-1:0] chip_count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int          cyc      = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          strobe_cyc[$];
   bit          src_q[$];
   bit          exp_q[$];

   codiq_chip_sequencer #(.DIV(DIV), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .abort      (abort),
      .frame_len  (frame_len),
      .chip_valid (chip_valid),
      .chip_data  (chip_data),
      .chip_ready (chip_ready),
      .coder_ready(coder_ready),
      .dac_ready  (dac_ready),
      .b_in       (b_in),
      .en_2MHz    (en_2MHz),
      .mem_state  (mem_state),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun),
      .chip_count (chip_count)
   );

   always #5 clk = ~clk;

   // One clock: advance to the edge, sample 1 ns later, compare strobes
   // against the scoreboard, model the upstream source.
   task automatic step();
      bit exp_b;
      @(posedge clk);
      #1;
      cyc++;
      if (en_2MHz === 1'b1) begin
         strobe_cyc.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_strobe: cycle %0d got strobe b_in=%0b, required no strobe", cyc, b_in);
         end else begin
            exp_b = exp_q.pop_front();
            if (b_in !== exp_b) begin
               n_fail++;
               $display("FAIL sb_b_in: cycle %0d got %0b, required %0b", cyc, b_in, exp_b);
            end
         end
         n_checks++;
         if (chip_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_chip_ready: cycle %0d got %0b, required 1 with strobe", cyc, chip_ready);
         end
      end
      if (chip_ready === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      chip_valid = (src_q.size() > 0);
      chip_data  = (src_q.size() > 0) ? src_q[0] : 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load_chip(input bit b);
      src_q.push_back(b);
      exp_q.push_back(b);
      chip_valid = 1'b1;
      chip_data  = src_q[0];
   endtask

   task automatic clear_queues();
      src_q.delete();
      exp_q.delete();
      strobe_cyc.delete();
      chip_valid = 1'b0;
      chip_data  = 1'b0;
   endtask

   // Issues a 1-cycle start; returns the edge number at which it was sampled.
   task automatic start_frame(input int len, output int n);
      start     = 1'b1;
      frame_len = LEN_W'(len);
      step();
      n         = cyc;
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) step();
      n_checks++;
      if (done_cnt == d0) begin
         n_fail++;
         $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, budget);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      steps(2);
      n_checks++;
      if ({en_2MHz, b_in, chip_ready, mem_state, busy, done, underrun} !== 7'b0 || chip_count !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got en=%b b=%b rdy=%b mem=%b busy=%b done=%b un=%b cnt=%0d, required all 0",
                  en_2MHz, b_in, chip_ready, mem_state, busy, done, underrun, chip_count);
      end
      resetn = 1'b1;
      steps(2);
      start     = 1'b1;
      frame_len = '0;
      step();
      start = 1'b0;
      steps(3);
      n_checks++;
      if (busy !== 1'b0 || mem_state !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_start: got busy=%b mem=%b, required 0 0", busy, mem_state);
      end
   endtask

   task automatic test_basic_frame();
      int n;
      int d0;
      clear_queues();
      load_chip(1'b1); load_chip(1'b0); load_chip(1'b1); load_chip(1'b1);
      d0 = done_cnt;
      start_frame(4, n);
      n_checks++;
      if (busy !== 1'b1 || mem_state !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_wait_dac: got busy=%b mem=%b, required 1 1", busy, mem_state);
      end
      wait_done(200, "basic");
      n_checks++;
      if (strobe_cyc.size() != 4) begin
         n_fail++;
         $display("FAIL basic_strobe_count: got %0d, required 4", strobe_cyc.size());
      end else begin
         n_checks++;
         if (strobe_cyc[0] != n + 2) begin
            n_fail++;
            $display("FAIL basic_first_latency: got edge %0d, required %0d", strobe_cyc[0], n + 2);
         end
         for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (strobe_cyc[i] - strobe_cyc[i-1] != DIV) begin
               n_fail++;
               $display("FAIL basic_spacing%0d: got %0d, required %0d", i, strobe_cyc[i] - strobe_cyc[i-1], DIV);
            end
         end
         n_checks++;
         if (done_cyc != strobe_cyc[3] + DIV + 1) begin
            n_fail++;
            $display("FAIL basic_done_time: got edge %0d, required %0d", done_cyc, strobe_cyc[3] + DIV + 1);
         end
      end
      n_checks++;
      if (chip_count !== 16'd4 || underrun !== 1'b0 || mem_state !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end_state: got cnt=%0d un=%b mem=%b busy=%b, required 4 0 0 0",
                  chip_count, underrun, mem_state, busy);
      end
      step();
      n_checks++;
      if (done !== 1'b0 || done_cnt != d0 + 1) begin
         n_fail++;
         $display("FAIL basic_done_pulse: got done=%b pulses=%0d, required 0 and %0d", done, done_cnt - d0, 1);
      end
   endtask

   task automatic test_stall();
      int n;
      int s0;
      clear_queues();
      load_chip(1'b0); load_chip(1'b1); load_chip(1'b1);
      start_frame(3, n);
      for (int i = 0; i < 50 && strobe_cyc.size() == 0; i++) step();
      s0 = (strobe_cyc.size() > 0) ? strobe_cyc[0] : cyc;
      while (cyc < s0 + DIV - 1) step();
      coder_ready = 1'b0;
      steps(10);
      coder_ready = 1'b1;
      wait_done(200, "stall");
      n_checks++;
      if (strobe_cyc.size() != 3) begin
         n_fail++;
         $display("FAIL stall_strobe_count: got %0d, required 3", strobe_cyc.size());
      end else begin
         n_checks++;
         if (strobe_cyc[1] - strobe_cyc[0] != DIV + 10) begin
            n_fail++;
            $display("FAIL stall_spacing1: got %0d, required %0d", strobe_cyc[1] - strobe_cyc[0], DIV + 10);
         end
         n_checks++;
         if (strobe_cyc[2] - strobe_cyc[1] != DIV) begin
            n_fail++;
            $display("FAIL stall_spacing2: got %0d, required %0d", strobe_cyc[2] - strobe_cyc[1], DIV);
         end
      end
      n_checks++;
      if (chip_count !== 16'd3) begin
         n_fail++;
         $display("FAIL stall_count: got %0d, required 3", chip_count);
      end
   endtask

   task automatic test_underrun();
      int n;
      int d0;
      clear_queues();
      load_chip(1'b1); load_chip(1'b0);
      d0 = done_cnt;
      start_frame(5, n);
      wait_done(300, "underrun");
      n_checks++;
      if (strobe_cyc.size() != 2) begin
         n_fail++;
         $display("FAIL underrun_strobes: got %0d, required 2", strobe_cyc.size());
      end else begin
         n_checks++;
         if (done_cyc != strobe_cyc[1] + DIV + DIV + 1) begin
            n_fail++;
            $display("FAIL underrun_done_time: got edge %0d, required %0d", done_cyc, strobe_cyc[1] + 2 * DIV + 1);
         end
      end
      n_checks++;
      if (underrun !== 1'b1 || chip_count !== 16'd2 || done_cnt != d0 + 1) begin
         n_fail++;
         $display("FAIL underrun_flags: got un=%b cnt=%0d dones=%0d, required 1 2 1",
                  underrun, chip_count, done_cnt - d0);
      end
      steps(3);
      n_checks++;
      if (underrun !== 1'b1) begin
         n_fail++;
         $display("FAIL underrun_sticky: got %b, required 1", underrun);
      end
      clear_queues();
      load_chip(1'b0);
      start_frame(1, n);
      n_checks++;
      if (underrun !== 1'b0 || chip_count !== '0) begin
         n_fail++;
         $display("FAIL underrun_clear: got un=%b cnt=%0d, required 0 0", underrun, chip_count);
      end
      wait_done(100, "underrun_next");
      n_checks++;
      if (chip_count !== 16'd1 || underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL underrun_next_frame: got cnt=%0d un=%b, required 1 0", chip_count, underrun);
      end
   endtask

   task automatic test_abort();
      int n;
      int s1;
      int d0;
      clear_queues();
      load_chip(1'b1); load_chip(1'b1); load_chip(1'b0); load_chip(1'b1);
      d0 = done_cnt;
      start_frame(4, n);
      for (int i = 0; i < 50 && strobe_cyc.size() == 0; i++) step();
      steps(3);
      start     = 1'b1;
      frame_len = LEN_W'(2);
      step();
      start = 1'b0;
      n_checks++;
      if (chip_count !== 16'd1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_start_ignored: got cnt=%0d busy=%b, required 1 1", chip_count, busy);
      end
      for (int i = 0; i < 60 && strobe_cyc.size() < 2; i++) step();
      s1 = (strobe_cyc.size() > 1) ? strobe_cyc[1] : cyc;
      while (cyc < s1 + 5) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || mem_state !== 1'b0 || en_2MHz !== 1'b0 || chip_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: got busy=%b mem=%b en=%b rdy=%b, required 0 0 0 0",
                  busy, mem_state, en_2MHz, chip_ready);
      end
      n_checks++;
      if (chip_count !== 16'd2 || underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_held: got cnt=%0d un=%b, required 2 0", chip_count, underrun);
      end
      exp_q.delete();
      steps(3 * DIV);
      n_checks++;
      if (done_cnt != d0 || strobe_cyc.size() != 2 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_quiet: got dones=%0d strobes=%0d busy=%b, required 0 2 0",
                  done_cnt - d0, strobe_cyc.size(), busy);
      end
   endtask

   task automatic test_async_reset();
      int n;
      clear_queues();
      load_chip(1'b1); load_chip(1'b1); load_chip(1'b0); load_chip(1'b0);
      start_frame(4, n);
      for (int i = 0; i < 50 && strobe_cyc.size() == 0; i++) step();
      steps(3);
      resetn = 1'b0;
      #2;
      n_checks++;
      if ({b_in, chip_ready, en_2MHz, mem_state, busy, done, underrun} !== 7'b0 || chip_count !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got b=%b rdy=%b en=%b mem=%b busy=%b done=%b un=%b cnt=%0d, required all 0",
                  b_in, chip_ready, en_2MHz, mem_state, busy, done, underrun, chip_count);
      end
      steps(2);
      resetn = 1'b1;
      clear_queues();
      steps(2);
      load_chip(1'b0); load_chip(1'b1);
      start_frame(2, n);
      wait_done(150, "post_reset");
      n_checks++;
      if (strobe_cyc.size() != 2 || chip_count !== 16'd2) begin
         n_fail++;
         $display("FAIL post_reset_frame: got strobes=%0d cnt=%0d, required 2 2", strobe_cyc.size(), chip_count);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d unissued chips, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_stall();
      test_underrun();
      test_abort();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
